// File: rtl/bullet_pool_if.sv
// bullet_pool_if: bus between the ship/input/raster logic and the bullet pool.
//   master : drives frame, fire, speed, ship origin, raster position, hit;
//            observes active, packed positions, fired, drawing, pixel.
//   slave  : the bullet pool itself.
interface bullet_pool_if #(
    parameter int N_BULLETS = 4,
    parameter int COORD_W   = 16,
    parameter int SPEED_W   = 8
);
    logic                           frame;
    logic                           fire;
    logic [SPEED_W-1:0]             speed;
    logic signed [COORD_W-1:0]      spaceship_x;
    logic signed [COORD_W-1:0]      spaceship_y;
    logic signed [COORD_W-1:0]      screen_x;
    logic signed [COORD_W-1:0]      screen_y;
    logic [N_BULLETS-1:0]           hit;
    logic [N_BULLETS-1:0]           active;
    logic [N_BULLETS*COORD_W-1:0]   bullet_x;
    logic [N_BULLETS*COORD_W-1:0]   bullet_y;
    logic                           fired;
    logic                           drawing;
    logic [3:0]                     pixel;

    modport master (
        output frame, fire, speed, spaceship_x, spaceship_y, screen_x, screen_y, hit,
        input  active, bullet_x, bullet_y, fired, drawing, pixel
    );

    modport slave (
        input  frame, fire, speed, spaceship_x, spaceship_y, screen_x, screen_y, hit,
        output active, bullet_x, bullet_y, fired, drawing, pixel
    );
endinterface

// File: rtl/bullet_pool.sv
// bullet_pool: pool of N_BULLETS player bullets.
//   - fire requests latch a pending flag; on a frame pulse the lowest free
//     slot is spawned at the ship (cooldown permitting), moving slots climb by
//     `speed` and retire above TOP_Y - BULLET_H; hit[i] kills slot i any cycle.
//   - drawing/pixel are registered one clock after the raster position.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bullet_pool_if.slave (frame, fire, speed, ship/raster coords,
//              hit in; active, bullet_x/y, fired, drawing, pixel out)
module bullet_pool #(
    parameter int         N_BULLETS = 4,
    parameter int         COORD_W   = 16,
    parameter int         SPEED_W   = 8,
    parameter int         BULLET_W  = 2,
    parameter int         BULLET_H  = 8,
    parameter int         COOLDOWN  = 8,
    parameter int         TOP_Y     = 0,
    parameter logic [3:0] COLOUR    = 4'hF
) (
    input logic          clk,
    input logic          rst,
    bullet_pool_if.slave bus
);
    localparam int CW1  = COORD_W + 1;
    localparam int CD_W = $clog2(COOLDOWN + 2);
    localparam logic signed [CW1-1:0] RETIRE_Y = CW1'(TOP_Y - BULLET_H);

    typedef enum logic {IDLE = 1'b0, MOVING = 1'b1} slot_e;

    slot_e                              state_q [N_BULLETS];
    slot_e                              state_d [N_BULLETS];
    logic [N_BULLETS-1:0][COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [CD_W-1:0]                    cd_q, cd_d;
    logic                               pend_q, pend_d;
    logic                               fired_q;
    logic                               drawing_q;
    logic [3:0]                         pixel_q;

    logic                               spawn;
    logic                               found;
    logic [N_BULLETS-1:0]               spawn_oh;
    logic signed [CW1-1:0]              y_mv [N_BULLETS];
    logic signed [COORD_W-1:0]          spawn_y;
    logic [N_BULLETS-1:0]               active_w;
    logic [N_BULLETS-1:0]               in_box;
    logic                               drawing_d;
    logic signed [CW1-1:0]              sx, sy;
    logic signed [CW1-1:0]              spd;

    assign spawn_y = bus.spaceship_y - COORD_W'(BULLET_H);
    assign sx      = {bus.screen_x[COORD_W-1], bus.screen_x};
    assign sy      = {bus.screen_y[COORD_W-1], bus.screen_y};
    assign spd     = {{(CW1-SPEED_W){1'b0}}, bus.speed};

    // Per-slot status and raster hit test, done in COORD_W+1 bits so the
    // upper box edge cannot wrap.
    for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
        logic signed [CW1-1:0] xl, yl;
        assign xl          = {x_q[g][COORD_W-1], x_q[g]};
        assign yl          = {y_q[g][COORD_W-1], y_q[g]};
        assign active_w[g] = (state_q[g] == MOVING);
        assign in_box[g]   = active_w[g]
                           && (sx >= xl) && (sx < xl + CW1'(BULLET_W))
                           && (sy >= yl) && (sy < yl + CW1'(BULLET_H));
    end

    assign drawing_d = |in_box;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cd_d     = cd_q;
        spawn_oh = '0;
        found    = 1'b0;

        // Eligibility is taken from registered state: a slot freed this very
        // cycle is still MOVING here and cannot be picked.
        for (int i = 0; i < N_BULLETS; i++) begin
            if (state_q[i] == IDLE && !found) begin
                spawn_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
        spawn = bus.frame && pend_q && (cd_q == '0) && found;

        for (int i = 0; i < N_BULLETS; i++) begin
            y_mv[i] = $signed({y_q[i][COORD_W-1], y_q[i]}) - spd;
            if (state_q[i] == MOVING) begin
                if (bus.hit[i]) begin
                    state_d[i] = IDLE;               // hit beats move
                end else if (bus.frame) begin
                    y_d[i] = y_mv[i][COORD_W-1:0];
                    if (y_mv[i] < RETIRE_Y)
                        state_d[i] = IDLE;
                end
            end else if (spawn && spawn_oh[i]) begin
                // Spawned slot does not move on its spawn frame.
                x_d[i]     = bus.spaceship_x;
                y_d[i]     = spawn_y;
                state_d[i] = MOVING;
            end
        end

        if (bus.frame) begin
            if (spawn)
                cd_d = CD_W'(COOLDOWN);
            else if (cd_q != '0)
                cd_d = cd_q - 1'b1;
        end

        // A fire in the spawn cycle is consumed by that spawn.
        pend_d = spawn ? 1'b0 : (pend_q | bus.fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BULLETS; i++) state_q[i] <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            cd_q      <= '0;
            pend_q    <= 1'b0;
            fired_q   <= 1'b0;
            drawing_q <= 1'b0;
            pixel_q   <= 4'h0;
        end else begin
            for (int i = 0; i < N_BULLETS; i++) state_q[i] <= state_d[i];
            x_q       <= x_d;
            y_q       <= y_d;
            cd_q      <= cd_d;
            pend_q    <= pend_d;
            fired_q   <= spawn;
            drawing_q <= drawing_d;
            pixel_q   <= drawing_d ? COLOUR : 4'h0;
        end
    end

    assign bus.active   = active_w;
    assign bus.bullet_x = x_q;
    assign bus.bullet_y = y_q;
    assign bus.fired    = fired_q;
    assign bus.drawing  = drawing_q;
    assign bus.pixel    = pixel_q;
endmodule

// File: tb/tb_bullet_pool.sv
module tb_bullet_pool;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    bullet_pool_if #(.N_BULLETS(4), .COORD_W(16), .SPEED_W(8)) bif ();

    bullet_pool #(
        .N_BULLETS(4), .COORD_W(16), .SPEED_W(8), .BULLET_W(2), .BULLET_H(8),
        .COOLDOWN(2), .TOP_Y(0), .COLOUR(4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    function automatic logic [15:0] xs(int i);
        return bif.bullet_x[i*16 +: 16];
    endfunction

    function automatic logic [15:0] ys(int i);
        return bif.bullet_y[i*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse(input logic [3:0] h);
        bif.frame = 1'b1;
        bif.hit   = h;
        tick();
        bif.frame = 1'b0;
        bif.hit   = 4'b0000;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++; if (bif.active !== 4'b0000) begin tests_failed++; $display("FAIL reset_active got %b want 0000", bif.active); end
        tests_run++; if (bif.bullet_x !== 64'd0) begin tests_failed++; $display("FAIL reset_bx got %h want 0", bif.bullet_x); end
        tests_run++; if (bif.bullet_y !== 64'd0) begin tests_failed++; $display("FAIL reset_by got %h want 0", bif.bullet_y); end
        tests_run++; if (bif.fired !== 1'b0) begin tests_failed++; $display("FAIL reset_fired got %b want 0", bif.fired); end
        tests_run++; if (bif.drawing !== 1'b0 || bif.pixel !== 4'h0) begin tests_failed++; $display("FAIL reset_draw got %b/%h want 0/0", bif.drawing, bif.pixel); end
    endtask

    task automatic test_spawn();
        bif.fire = 1'b1;
        tick();
        bif.fire = 1'b0;
        tick();
        frame_pulse(4'b0000);
        tests_run++; if (bif.fired !== 1'b1) begin tests_failed++; $display("FAIL spawn_fired got %b want 1", bif.fired); end
        tests_run++; if (bif.active !== 4'b0001) begin tests_failed++; $display("FAIL spawn_active got %b want 0001", bif.active); end
        tests_run++; if (xs(0) !== 16'd10 || ys(0) !== 16'd92) begin tests_failed++; $display("FAIL spawn_pos got (%0d,%0d) want (10,92)", xs(0), ys(0)); end
        tick();
        tests_run++; if (bif.fired !== 1'b0) begin tests_failed++; $display("FAIL spawn_fired_pulse got %b want 0", bif.fired); end
    endtask

    task automatic test_render();
        bif.screen_x = 16'sd10; bif.screen_y = 16'sd92; tick();
        tests_run++; if (bif.drawing !== 1'b1 || bif.pixel !== 4'hF) begin tests_failed++; $display("FAIL render_corner got %b/%h want 1/F", bif.drawing, bif.pixel); end
        bif.screen_x = 16'sd11; bif.screen_y = 16'sd99; tick();
        tests_run++; if (bif.drawing !== 1'b1) begin tests_failed++; $display("FAIL render_far_corner got %b want 1", bif.drawing); end
        bif.screen_x = 16'sd12; bif.screen_y = 16'sd92; tick();
        tests_run++; if (bif.drawing !== 1'b0 || bif.pixel !== 4'h0) begin tests_failed++; $display("FAIL render_right_edge got %b/%h want 0/0", bif.drawing, bif.pixel); end
        bif.screen_x = 16'sd11; bif.screen_y = 16'sd100; tick();
        tests_run++; if (bif.drawing !== 1'b0) begin tests_failed++; $display("FAIL render_bottom_edge got %b want 0", bif.drawing); end
        bif.screen_x = 16'sd9; bif.screen_y = 16'sd95; tick();
        tests_run++; if (bif.drawing !== 1'b0) begin tests_failed++; $display("FAIL render_left_edge got %b want 0", bif.drawing); end
        bif.screen_x = 16'sd500; bif.screen_y = 16'sd500; tick();
    endtask

    task automatic test_move_retire();
        frame_pulse(4'b0000); tick();
        tests_run++; if (ys(0) !== 16'd88) begin tests_failed++; $display("FAIL move_first got %0d want 88", ys(0)); end
        repeat (24) begin frame_pulse(4'b0000); tick(); end
        tests_run++; if (ys(0) !== 16'hFFF8 || bif.active[0] !== 1'b1) begin tests_failed++; $display("FAIL retire_edge got y=%h act=%b want fff8/1", ys(0), bif.active[0]); end
        frame_pulse(4'b0000); tick();
        tests_run++; if (bif.active[0] !== 1'b0) begin tests_failed++; $display("FAIL retire got %b want 0", bif.active[0]); end
    endtask

    task automatic test_back_to_back();
        logic exp_f;
        apply_reset();
        bif.fire = 1'b1;
        tick();
        for (int f = 1; f <= 10; f++) begin
            frame_pulse(4'b0000);
            exp_f = (f == 1 || f == 4 || f == 7 || f == 10);
            tests_run++; if (bif.fired !== exp_f) begin tests_failed++; $display("FAIL b2b_fired f=%0d got %b want %b", f, bif.fired, exp_f); end
            if (f == 7) begin
                tests_run++; if (bif.active !== 4'b0111) begin tests_failed++; $display("FAIL b2b_active got %b want 0111", bif.active); end
                tests_run++; if (ys(0) !== 16'd68 || ys(1) !== 16'd80 || ys(2) !== 16'd92) begin tests_failed++; $display("FAIL b2b_pos got %0d/%0d/%0d want 68/80/92", ys(0), ys(1), ys(2)); end
            end
            tick();
        end
        tests_run++; if (bif.active !== 4'b1111) begin tests_failed++; $display("FAIL full_active got %b want 1111", bif.active); end
    endtask

    task automatic test_full_hit_respawn();
        frame_pulse(4'b0000); tick();      // 11
        frame_pulse(4'b0000); tick();      // 12, cooldown reaches 0
        frame_pulse(4'b0000);              // 13, no free slot
        tests_run++; if (bif.fired !== 1'b0 || bif.active !== 4'b1111) begin tests_failed++; $display("FAIL full_nospawn got %b/%b want 0/1111", bif.fired, bif.active); end
        tick();
        frame_pulse(4'b0100);              // 14, hit slot2 on the frame
        tests_run++; if (bif.fired !== 1'b0 || bif.active !== 4'b1011) begin tests_failed++; $display("FAIL hit_frame got %b/%b want 0/1011", bif.fired, bif.active); end
        tests_run++; if (ys(2) !== 16'd68) begin tests_failed++; $display("FAIL hit_no_move got %0d want 68", ys(2)); end
        tick();
        bif.spaceship_x = 16'sd50;
        frame_pulse(4'b0000);              // 15, respawn into slot2
        bif.fire = 1'b0;
        tests_run++; if (bif.fired !== 1'b1 || bif.active !== 4'b1111) begin tests_failed++; $display("FAIL respawn got %b/%b want 1/1111", bif.fired, bif.active); end
        tests_run++; if (xs(2) !== 16'd50 || ys(2) !== 16'd92) begin tests_failed++; $display("FAIL respawn_pos got (%0d,%0d) want (50,92)", xs(2), ys(2)); end
        tests_run++; if (ys(0) !== 16'd36 || ys(1) !== 16'd48 || ys(3) !== 16'd72) begin tests_failed++; $display("FAIL others_move got %0d/%0d/%0d want 36/48/72", ys(0), ys(1), ys(3)); end
        tests_run++; if (xs(0) !== 16'd10 || xs(3) !== 16'd10) begin tests_failed++; $display("FAIL others_x got %0d/%0d want 10/10", xs(0), xs(3)); end
        tick();
        frame_pulse(4'b0100); tick();      // 16, slot2 killed, frees a slot
        frame_pulse(4'b0000); tick();      // 17
        frame_pulse(4'b0000);              // 18, cooldown 0, free slot, fire was consumed
        tests_run++; if (bif.fired !== 1'b0 || bif.active !== 4'b1011) begin tests_failed++; $display("FAIL fire_consumed got %b/%b want 0/1011", bif.fired, bif.active); end
        tick();
    endtask

    task automatic test_hit_render();
        // slot1 spawned on frame 4: y = 92 - 4*14 = 36 after frame 18
        bif.screen_x = 16'sd10; bif.screen_y = 16'sd36; tick();
        tests_run++; if (bif.drawing !== 1'b1) begin tests_failed++; $display("FAIL hit_render_pre got %b want 1", bif.drawing); end
        bif.hit = 4'b0010; tick(); bif.hit = 4'b0000; tick();
        tests_run++; if (bif.drawing !== 1'b0 || bif.active !== 4'b1001) begin tests_failed++; $display("FAIL hit_render_post got %b/%b want 0/1001", bif.drawing, bif.active); end
        bif.hit = 4'b0110; tick(); bif.hit = 4'b0000; tick();
        tests_run++; if (bif.active !== 4'b1001) begin tests_failed++; $display("FAIL hit_idle got %b want 1001", bif.active); end
    endtask

    task automatic test_async_reset();
        // slot3 spawned on frame 10: y = 92 - 4*8 = 60 after frame 18
        bif.screen_x = 16'sd10; bif.screen_y = 16'sd60; tick();
        tests_run++; if (bif.drawing !== 1'b1) begin tests_failed++; $display("FAIL arst_pre got %b want 1", bif.drawing); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (bif.active !== 4'b0000 || bif.bullet_x !== 64'd0 || bif.bullet_y !== 64'd0) begin tests_failed++; $display("FAIL arst_slots got %b %h %h want 0", bif.active, bif.bullet_x, bif.bullet_y); end
        tests_run++; if (bif.drawing !== 1'b0 || bif.pixel !== 4'h0 || bif.fired !== 1'b0) begin tests_failed++; $display("FAIL arst_out got %b/%h/%b want 0/0/0", bif.drawing, bif.pixel, bif.fired); end
        tick();
        rst = 1'b0;
        bif.screen_x = 16'sd500; bif.screen_y = 16'sd500;
        bif.spaceship_x = 16'sd10;
        bif.fire = 1'b1; tick(); bif.fire = 1'b0; tick();
        frame_pulse(4'b0000);
        tests_run++; if (bif.fired !== 1'b1 || bif.active !== 4'b0001) begin tests_failed++; $display("FAIL arst_respawn got %b/%b want 1/0001", bif.fired, bif.active); end
        tests_run++; if (xs(0) !== 16'd10 || ys(0) !== 16'd92) begin tests_failed++; $display("FAIL arst_pos got (%0d,%0d) want (10,92)", xs(0), ys(0)); end
    endtask

    initial begin
        bif.frame       = 1'b0;
        bif.fire        = 1'b0;
        bif.speed       = 8'd4;
        bif.spaceship_x = 16'sd10;
        bif.spaceship_y = 16'sd100;
        bif.screen_x    = 16'sd500;
        bif.screen_y    = 16'sd500;
        bif.hit         = 4'b0000;
        test_reset();
        test_spawn();
        test_render();
        test_move_retire();
        test_back_to_back();
        test_full_hit_respawn();
        test_hit_render();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
Multi-slot successor to the single-bullet block. It manages up to N_BULLETS concurrent player bullets with a per-frame fire cooldown and lowest-free-slot allocation. Each bullet moves up by a programmable speed every frame, retires on leaving the top of the screen or on an external hit, and is rendered against the current raster position. It sits between the spaceship/input logic and the collision and pixel-mux logic.

Parameters:
N_BULLETS, 4, number of bullet slots (1..16)
COORD_W, 16, signed coordinate width
SPEED_W, 8, unsigned speed width (pixels per frame)
BULLET_W, 2, bullet width in pixels
BULLET_H, 8, bullet height in pixels
COOLDOWN, 8, frames between spawns minus one (0 = spawn every frame)
TOP_Y, 0, top screen edge used for retirement
COLOUR, 4'hF, pixel value while drawing

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
frame  in  1  one-cycle pulse at frame start; all movement, spawn and cooldown updates happen only on this cycle
fire  in  1  fire request; any high cycle sets the pending flag
speed  in  SPEED_W  per-frame upward displacement, sampled on frame
spaceship_x, spaceship_y  in  COORD_W signed  ship origin, sampled at spawn
screen_x, screen_y  in  COORD_W signed  current raster position
hit  in  N_BULLETS  hit[i] high for one cycle kills slot i
active  out  N_BULLETS  slot i is MOVING
bullet_x, bullet_y  out  N_BULLETS*COORD_W  packed per-slot positions; slot i at [i*COORD_W +: COORD_W]
fired  out  1  one-cycle pulse on each spawn
drawing  out  1  raster is inside some active bullet
pixel  out  4  COLOUR when drawing, else 0

Behaviour:
- Reset (async, active-high) forces:
  - all slots IDLE; active=0; bullet_x/bullet_y=0
  - cooldown=0; pending=0
  - fired=0; drawing=0; pixel=0
  - takes effect immediately, including mid-flight; release resumes with the next frame pulse.
- Per-slot FSM, two states:
  - IDLE -> MOVING on spawn.
  - MOVING -> IDLE on hit[i] (any cycle) or on retirement (frame cycle).
  - hit[i] on an IDLE slot is ignored.
- Pending flag:
  - set on any cycle with fire=1
  - cleared only on the frame cycle in which a spawn occurs
  - fire and a spawn in the same cycle: flag stays cleared (spawn wins; that fire is consumed).
- On a frame cycle, evaluated from registered state:
  - Move: each MOVING slot not hit this cycle gets y <= y - speed. Compute in COORD_W+1 signed, speed zero-extended.
  - Retire: if the new y < TOP_Y - BULLET_H, the slot goes IDLE. y keeps its last written value.
  - Spawn: if pending=1, cooldown=0 and at least one IDLE slot exists, the lowest-index IDLE slot gets x=spaceship_x, y=spaceship_y-BULLET_H, state MOVING. cooldown is loaded with COOLDOWN and fired pulses for one cycle. A spawned bullet does not move on its spawn frame.
  - Cooldown: otherwise, if cooldown != 0 it decrements by 1. Spawns are therefore spaced COOLDOWN+1 frames apart.
  - No free slot: pending stays set and the spawn retries on later frames.
- Simultaneous events:
  - A slot freed by hit or retirement on a frame cycle is not eligible for spawn until the next frame.
  - hit has priority over move on the same slot.
- Render, registered, latency 1 clk:
  - drawing <= OR over MOVING slots of (x <= screen_x < x+BULLET_W and y <= screen_y < y+BULLET_H)
  - compare in COORD_W+1 signed to avoid overflow
  - pixel <= drawing_next ? COLOUR : 0
- speed=0: bullets stay in place and retire only by hit.

Test Plan:
1. Defaults with COOLDOWN=2, ship (10,100), speed=4; pulse fire, then frame -> fired one cycle, active=0001, slot0=(10,92); next frame y=88.
2. Same bullet, frames continue -> y reaches -8 after 25 moves and stays active; 26th move (y=-12 < -8) -> active[0]=0.
3. fire held high, COOLDOWN=2 -> spawns on frames 1, 4, 7 into slots 0, 1, 2; fired high exactly on those frames.
4. COOLDOWN=0, all 4 slots active, fire pending; hit[2] pulsed on a frame cycle -> no spawn that frame; next frame slot2 respawns at the ship, other slots are unaffected and move by 4.
5. Slot0 at (10,92), BULLET_W=2, BULLET_H=8; raster (10,92) -> drawing=1, pixel=F one clk later; (11,99) -> 1; (12,92) -> 0; (11,100) -> 0; after hit[0] -> 0 everywhere.
6. Assert rst mid-flight between clock edges -> active, bullet_x/bullet_y, drawing, pixel and fired drop to 0 without waiting for clk; after release, a fire request spawns into slot0 with cooldown=0.
